// File: rtl/tlul_data_intg_chk_pipe.sv
// Multi-lane inverted-SECDED(39,32) integrity checker: one-stage valid/ready pipe,
// sticky/counted error statistics and a four-phase alert handshake.

module tlul_data_intg_chk_lane (
  input  logic [38:0] cw_i,
  output logic [31:0] data_o,
  output logic        single_o,
  output logic        double_o
);
  localparam logic [38:0] InvMask = {7'h2A, 32'h0};
  localparam logic [6:0][31:0] HMask = {
    32'h98505586, 32'h2DCC624C, 32'hC2C1323B, 32'h31234ED1,
    32'h413D89AA, 32'hDEBA8050, 32'h2606BD25
  };

  logic [38:0] cw;
  logic [6:0]  syn;

  assign cw = cw_i ^ InvMask;

  always_comb begin
    syn = '0;
    for (int i = 0; i < 7; i++) syn[i] = ^(cw[31:0] & HMask[i]) ^ cw[32+i];
  end

  // Hsiao columns all have odd weight, so syndrome parity separates single from double.
  assign single_o = (|syn) &  (^syn);
  assign double_o = (|syn) & ~(^syn);
  assign data_o   = cw_i[31:0];
endmodule

module tlul_data_intg_chk_pipe #(
  parameter int NumLanes    = 1,
  parameter int DataWidth   = 32,
  parameter int IntgWidth   = 7,
  parameter int ErrCntWidth = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [NumLanes*(DataWidth+IntgWidth)-1:0] in_data_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [NumLanes*DataWidth-1:0]          out_data_o,
  output logic [NumLanes*2-1:0]                  out_lane_err_o,
  output logic                                   out_err_o,
  output logic                                   err_sticky_o,
  output logic [ErrCntWidth-1:0]                 err_cnt_o,
  input  logic                                   clr_i,
  output logic                                   alert_req_o,
  input  logic                                   alert_ack_i
);
  typedef enum logic [1:0] {StIdle, StReq, StWaitLow} alert_st_e;

  logic [NumLanes-1:0][DataWidth-1:0] lane_data;
  logic [NumLanes-1:0]                lane_single, lane_double;
  logic [NumLanes-1:0][1:0]           lane_err;
  logic                               beat_err, accept, err_beat;

  logic                               out_valid_q, out_valid_d;
  logic [NumLanes*DataWidth-1:0]      out_data_q, out_data_d;
  logic [NumLanes*2-1:0]              out_lane_err_q, out_lane_err_d;
  logic                               out_err_q, out_err_d;
  logic                               err_sticky_q, err_sticky_d;
  logic [ErrCntWidth-1:0]             err_cnt_q, err_cnt_d;
  logic                               pending_q, pending_d;
  alert_st_e                          state_q, state_d;

  tlul_data_intg_chk_lane u_lane [NumLanes-1:0] (
    .cw_i     (in_data_i),
    .data_o   (lane_data),
    .single_o (lane_single),
    .double_o (lane_double)
  );

  always_comb begin
    lane_err = '0;
    for (int k = 0; k < NumLanes; k++) lane_err[k] = {lane_double[k], lane_single[k]};
  end

  assign beat_err   = |lane_err;
  assign in_ready_o = !out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign err_beat   = accept & beat_err;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_lane_err_d = out_lane_err_q;
    out_err_d      = out_err_q;
    if (accept) begin
      out_valid_d    = 1'b1;
      out_data_d     = lane_data;
      out_lane_err_d = lane_err;
      out_err_d      = beat_err;
    end else if (out_ready_i) begin
      out_valid_d    = 1'b0;
    end
  end

  // A clear coinciding with an erroneous beat leaves exactly that beat counted.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (clr_i) begin
      err_sticky_d = err_beat;
      err_cnt_d    = {{(ErrCntWidth-1){1'b0}}, err_beat};
    end else if (err_beat) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + {{(ErrCntWidth-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (err_beat || pending_q) begin
          state_d   = StReq;
          pending_d = 1'b0;
        end
      end
      StReq: begin
        if (err_beat) pending_d = 1'b1;
        if (alert_ack_i) state_d = StWaitLow;
      end
      StWaitLow: begin
        if (err_beat) pending_d = 1'b1;
        if (!alert_ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_lane_err_q <= '0;
      out_err_q      <= 1'b0;
      err_sticky_q   <= 1'b0;
      err_cnt_q      <= '0;
      pending_q      <= 1'b0;
      state_q        <= StIdle;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_lane_err_q <= out_lane_err_d;
      out_err_q      <= out_err_d;
      err_sticky_q   <= err_sticky_d;
      err_cnt_q      <= err_cnt_d;
      pending_q      <= pending_d;
      state_q        <= state_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_lane_err_o = out_lane_err_q;
  assign out_err_o      = out_err_q;
  assign err_sticky_o   = err_sticky_q;
  assign err_cnt_o      = err_cnt_q;
  assign alert_req_o    = (state_q == StReq);
endmodule
